// File: rtl/binarize_stream_if.sv
// -----------------------------------------------------------------------------
// binarize_stream_if
//   Pixel stream bundle for binarize_stream. It carries the input pixel stream
//   (source -> block) and the binarized output stream (block -> sink).
//
//   Signals:
//     in_valid   source has a pixel on in_data
//     in_ready   block accepts a pixel this cycle
//     in_data    input pixel, PIX_W bits
//     out_valid  block has a binarized pixel on out_data
//     out_ready  sink accepts the output pixel
//     out_data   binarized pixel, all-ones or zero
//     out_last   marks the final pixel of the frame
//
//   Modports:
//     master  the side that sources pixels and sinks results (bench / system)
//     slave   the binarizer itself
// -----------------------------------------------------------------------------
interface binarize_stream_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/binarize_stream.sv
// -----------------------------------------------------------------------------
// binarize_stream
//   Accepts one frame of NPIX pixels, buffers it while building a 2^PIX_W-bin
//   histogram, derives a threshold (median, mean or fixed) and then replays the
//   buffered frame as binary pixels (all-ones / zero).
//
//   Ports:
//     clk         clock, all logic on the rising edge
//     rst         asynchronous active-high reset; discards any frame in flight
//     cfg_mode    0=median, 1=mean, 2=fixed, 3=median; latched on first pixel
//     cfg_thresh  threshold for fixed mode; latched on first pixel
//     cfg_invert  swap the output polarity; latched on first pixel
//     strm        pixel stream bundle (in_* input stream, out_* output stream)
//     thresh      threshold of the current / most recent frame
//     busy        high while a frame is being filled, scanned or emitted
//     frame_done  one-cycle pulse after the last output handshake
// -----------------------------------------------------------------------------
module binarize_stream #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 1024,
    parameter int CNT_W = $clog2(NPIX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [PIX_W-1:0] cfg_thresh,
    input  logic             cfg_invert,
    binarize_stream_if.slave strm,
    output logic [PIX_W-1:0] thresh,
    output logic             busy,
    output logic             frame_done
);
    localparam int NBINS = 1 << PIX_W;
    localparam int AW    = $clog2(NPIX);
    localparam int SUM_W = PIX_W + AW;

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(NPIX / 2);
    localparam logic [AW-1:0]    LAST_WR  = AW'(NPIX - 1);
    localparam logic [AW:0]      RD_TOTAL = (AW + 1)'(NPIX);
    localparam logic [AW:0]      RD_FINAL = (AW + 1)'(NPIX - 1);

    generate
        if (NPIX < 2 || (NPIX & (NPIX - 1)) != 0) begin : g_npix_check
            $error("binarize_stream: NPIX must be a power of 2 (at least 2)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Frame configuration, frozen at the first accepted pixel
    logic [1:0]       mode_reg;
    logic [PIX_W-1:0] cfg_thresh_reg;
    logic             invert_reg;

    // Fill side
    logic [AW-1:0]    wr_addr_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [CNT_W-1:0] hist [NBINS];

    // Scan side
    logic [PIX_W-1:0] scan_idx_reg;
    logic [CNT_W-1:0] cdf_reg;
    logic [PIX_W-1:0] med_reg;
    logic             found_reg;
    logic [PIX_W-1:0] thresh_reg;

    // Emit side: frame buffer read stage followed by the output register
    logic [PIX_W-1:0] frame_mem [NPIX];
    logic [PIX_W-1:0] rd_q;
    logic [AW:0]      rd_cnt_reg;
    logic             rd_valid_reg;
    logic             rd_last_reg;
    logic             out_valid_reg;
    logic [PIX_W-1:0] out_data_reg;
    logic             out_last_reg;
    logic             frame_done_reg;

    logic             in_ready_int;
    logic             busy_int;
    logic             in_fire;
    logic             out_fire;
    logic             wr_last;
    logic             scan_last;
    logic [CNT_W-1:0] cdf_next;
    logic             median_hit;
    logic [PIX_W-1:0] median_val;
    logic [PIX_W-1:0] mean_val;
    logic [PIX_W-1:0] thresh_sel;
    logic             load_out;
    logic             rd_issue;
    logic             out_bit;

    // in_ready follows the state only; it is also held low while rst is asserted
    assign in_ready_int = ((state_reg == IDLE) || (state_reg == FILL)) && !rst;
    assign in_fire      = strm.in_valid && in_ready_int;
    assign out_fire     = out_valid_reg && strm.out_ready;
    assign wr_last      = (wr_addr_reg == LAST_WR);
    assign scan_last    = (scan_idx_reg == {PIX_W{1'b1}});

    assign cdf_next   = cdf_reg + hist[scan_idx_reg];
    assign median_hit = !found_reg && (cdf_next >= HALF);
    // If the median bin was not seen earlier, the bin being read now is it
    assign median_val = found_reg ? med_reg : scan_idx_reg;
    assign mean_val   = PIX_W'(sum_reg >> AW);

    always_comb begin
        thresh_sel = median_val;
        case (mode_reg)
            2'd1:    thresh_sel = mean_val;
            2'd2:    thresh_sel = cfg_thresh_reg;
            default: thresh_sel = median_val;
        endcase
    end

    // The read stage is refilled whenever it is empty or is handing its pixel
    // to the output register in this same cycle, giving one pixel per cycle.
    assign load_out = rd_valid_reg && (!out_valid_reg || out_fire);
    assign rd_issue = (state_reg == EMIT) && (rd_cnt_reg != RD_TOTAL) &&
                      (!rd_valid_reg || load_out);

    assign out_bit = (rd_q > thresh_reg) ^ invert_reg;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_int   = 1'b1;
        case (state_reg)
            IDLE: begin
                busy_int = 1'b0;
                if (in_fire) begin
                    state_next = wr_last ? SCAN : FILL;
                end
            end
            FILL: begin
                if (in_fire && wr_last) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_fire && out_last_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------- histogram
    // Bins are incremented during fill and cleared as the scan reads them,
    // so every frame starts from an empty histogram without a clear pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBINS; i++) begin
                hist[i] <= '0;
            end
        end else if (in_fire) begin
            hist[strm.in_data] <= hist[strm.in_data] + CNT_W'(1);
        end else if (state_reg == SCAN) begin
            hist[scan_idx_reg] <= '0;
        end
    end

    // -------------------------------------------------------- frame buffer
    always_ff @(posedge clk) begin
        if (in_fire) begin
            frame_mem[wr_addr_reg] <= strm.in_data;
        end
        if (rd_issue) begin
            rd_q <= frame_mem[rd_cnt_reg[AW-1:0]];
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg       <= '0;
            cfg_thresh_reg <= '0;
            invert_reg     <= 1'b0;
            wr_addr_reg    <= '0;
            sum_reg        <= '0;
            scan_idx_reg   <= '0;
            cdf_reg        <= '0;
            med_reg        <= '0;
            found_reg      <= 1'b0;
            thresh_reg     <= '0;
            rd_cnt_reg     <= '0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE, FILL: begin
                    if (in_fire) begin
                        if (state_reg == IDLE) begin
                            mode_reg       <= cfg_mode;
                            cfg_thresh_reg <= cfg_thresh;
                            invert_reg     <= cfg_invert;
                            sum_reg        <= SUM_W'(strm.in_data);
                            scan_idx_reg   <= '0;
                            cdf_reg        <= '0;
                            found_reg      <= 1'b0;
                        end else begin
                            sum_reg <= sum_reg + SUM_W'(strm.in_data);
                        end
                        // Wraps back to 0 after the NPIXth pixel
                        wr_addr_reg <= wr_addr_reg + AW'(1);
                    end
                end
                SCAN: begin
                    cdf_reg      <= cdf_next;
                    scan_idx_reg <= scan_idx_reg + PIX_W'(1);
                    if (median_hit) begin
                        found_reg <= 1'b1;
                        med_reg   <= scan_idx_reg;
                    end
                    if (scan_last) begin
                        thresh_reg   <= thresh_sel;
                        rd_cnt_reg   <= '0;
                        rd_valid_reg <= 1'b0;
                    end
                end
                EMIT: begin
                    if (rd_issue) begin
                        rd_cnt_reg   <= rd_cnt_reg + (AW + 1)'(1);
                        rd_valid_reg <= 1'b1;
                        rd_last_reg  <= (rd_cnt_reg == RD_FINAL);
                    end else if (load_out) begin
                        rd_valid_reg <= 1'b0;
                    end

                    if (load_out) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= {PIX_W{out_bit}};
                        out_last_reg  <= rd_last_reg;
                    end else if (out_fire) begin
                        out_valid_reg <= 1'b0;
                    end

                    if (out_fire && out_last_reg) begin
                        out_valid_reg  <= 1'b0;
                        out_last_reg   <= 1'b0;
                        frame_done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign strm.in_ready  = in_ready_int;
    assign strm.out_valid = out_valid_reg;
    assign strm.out_data  = out_data_reg;
    assign strm.out_last  = out_last_reg;
    assign thresh         = thresh_reg;
    assign busy           = busy_int;
    assign frame_done     = frame_done_reg;
endmodule
